regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Read-side debug engine for the 16x32 triple-port register file.
- On a start request it walks every register through one read port, latches each 32-bit value, and streams it out as bytes over a valid/ready byte interface that feeds the debug UART transmitter.
- Sits between the register file read port (shared with the CPU via a hold signal) and the debug serial link.

Parameters:
- NREGS, 16, number of registers dumped (indices 0..NREGS-1)
- RNO_W, 4, register index width
- DATA_W, 32, register width; must be a multiple of 8

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  dump request pulse; sampled only in IDLE
- hold  output  1  high while busy; CPU must not use the shared read port
- rno  output  RNO_W  register index driven to the register file read port
- rdata  input  DATA_W  register file read data (combinational for rno)
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts byte when tx_valid&tx_ready
- done  output  1  single-cycle pulse after the final byte is accepted

Behaviour:
- Reset (async, immediate): state=IDLE; hold=0, rno=0, tx_data=0, tx_valid=0, done=0; index, byte counter and shift register=0.
- States: IDLE, FETCH, SEND, NEXT, FIN.
- IDLE: start=1 -> FETCH; index=0, hold=1 from the next cycle. start=0 -> stay.
- FETCH (1 cycle): rno=index; at the clock edge, shift register <= rdata and byte counter <= DATA_W/8-1; -> SEND.
- SEND: tx_valid=1, tx_data=shift[DATA_W-1 -: 8] (MSB byte first). On tx_valid&tx_ready: shift <<= 8. If byte counter=0 -> NEXT, else decrement the counter.
- tx_data and tx_valid are held stable while tx_ready=0. tx_valid never drops without acceptance, except on reset.
- NEXT (1 cycle, tx_valid=0): if index=NREGS-1 -> FIN; else index+1 -> FETCH. The index does not wrap.
- FIN (1 cycle): done=1, hold=0 in this cycle -> IDLE.
- Latency with tx_ready tied high: FETCH 1 + SEND 4 + NEXT 1 per register. Total 16*6+1 = 97 cycles from the first FETCH to the done pulse.
- start while not IDLE: ignored; there is no queuing.
- start and tx_ready asserted together in IDLE: only start has effect.
- hold is asserted in FETCH, SEND, NEXT and FIN-entry. rno is stable at index in every non-IDLE state.
- Reset mid-dump: aborts with no done pulse. A partial byte stream is acceptable.

Optional Feature:
- Macro REGDUMP_FRAME_EN.
- Defined:
  - Adds state HDR before the first FETCH, emitting byte 8'hA5.
  - Adds state SUM after the last NEXT, emitting an 8-bit XOR of all data bytes sent (header excluded).
  - Both bytes follow the same valid/ready rules.
  - Done is asserted after the SUM byte is accepted.
  - Total bytes: 4*NREGS+2. The checksum register resets to 0 on start.
- Undefined:
  - Exactly 4*NREGS raw bytes.
  - No HDR/SUM states and no checksum logic.

Test Plan:
- Model R[i]=32'h1000_0000+i; tx_ready=1; pulse start -> 64 bytes 10,00,00,00,10,00,00,01,...,10,00,00,0F in order; done pulses once at cycle 97 after start-accept; hold high throughout.
- tx_ready toggles 1-of-3 cycles with R[0]=32'hDEADBEEF -> first bytes DE,AD,BE,EF, each held stable until accepted; no byte is duplicated or lost.
- Pulse start again mid-dump at byte 20 -> ignored; the stream stays 64 bytes and exactly one done pulse occurs.
- Assert rst during SEND of register 5 -> tx_valid, hold and done go 0 immediately, with no done pulse; a new start then dumps from R[0].
- REGDUMP_FRAME_EN defined, all R[i]=32'h0101_0101 -> A5, 64x 01, then checksum 00. Set R[3]=32'h0101_0181 -> checksum 80.
- All registers 0, tx_ready held low for 50 cycles after start -> tx_valid=1 with tx_data=00 stable, state in SEND, rno=0, no done pulse.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Handshake bundle between the register-dump engine, the shared register file
// read port and the debug UART byte transmitter.
interface regfile_dump_reader_if #(
    parameter int RNO_W  = 4,
    parameter int DATA_W = 32
);
    logic              start;
    logic              hold;
    logic [RNO_W-1:0]  rno;
    logic [DATA_W-1:0] rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              done;

    modport master (
        input  start, rdata, tx_ready,
        output hold, rno, tx_data, tx_valid, done
    );

    modport slave (
        output start, rdata, tx_ready,
        input  hold, rno, tx_data, tx_valid, done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register through the shared read port and streams each value MSB
// byte first over valid/ready. REGDUMP_FRAME_EN adds an A5 header and XOR checksum byte.
module regfile_dump_reader #(
    parameter int NREGS  = 16,
    parameter int RNO_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_dump_reader_if.master bus
);
    localparam int NB   = DATA_W / 8;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;
`ifdef REGDUMP_FRAME_EN
    localparam logic [2:0] S_HDR   = 3'd5;
    localparam logic [2:0] S_SUM   = 3'd6;
`endif

    logic [2:0]        state;
    logic [RNO_W-1:0]  idx;
    logic [BC_W-1:0]   bcnt;
    logic [DATA_W-1:0] shift;
    logic              accept;
`ifdef REGDUMP_FRAME_EN
    logic [7:0]        csum;
`endif

    assign accept = bus.tx_valid & bus.tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            bcnt  <= '0;
            shift <= '0;
`ifdef REGDUMP_FRAME_EN
            csum  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    idx   <= '0;
`ifdef REGDUMP_FRAME_EN
                    csum  <= '0;
                    state <= S_HDR;
`else
                    state <= S_FETCH;
`endif
                end
`ifdef REGDUMP_FRAME_EN
                S_HDR: if (accept) state <= S_FETCH;
                S_SUM: if (accept) state <= S_FIN;
`endif
                S_FETCH: begin
                    shift <= bus.rdata;
                    bcnt  <= BC_W'(NB - 1);
                    state <= S_SEND;
                end
                S_SEND: if (accept) begin
                    shift <= shift << 8;
`ifdef REGDUMP_FRAME_EN
                    csum  <= csum ^ shift[DATA_W-1 -: 8];
`endif
                    if (bcnt == '0) state <= S_NEXT;
                    else            bcnt  <= bcnt - BC_W'(1);
                end
                S_NEXT: begin
                    // the index saturates at the last register; no wrap
                    if (idx == RNO_W'(NREGS - 1)) begin
`ifdef REGDUMP_FRAME_EN
                        state <= S_SUM;
`else
                        state <= S_FIN;
`endif
                    end else begin
                        idx   <= idx + RNO_W'(1);
                        state <= S_FETCH;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them immediately.
    always_comb begin
        bus.hold     = (state != S_IDLE) && (state != S_FIN);
        bus.rno      = (state == S_IDLE) ? '0 : idx;
        bus.done     = (state == S_FIN);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        if (state == S_SEND) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = shift[DATA_W-1 -: 8];
        end
`ifdef REGDUMP_FRAME_EN
        if (state == S_HDR) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'hA5;
        end
        if (state == S_SUM) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = csum;
        end
`endif
    end
endmodule
